// File: rtl/formula_loader_pkg.sv
// Shared constants and loader state type for the formula loader slice.
package common;

    localparam int number_literal = 5;
    localparam int number_clause  = 16;

    typedef enum logic [1:0] {
        IDLE,
        POS,
        NEG,
        DONE
    } loader_state_t;

endpackage

// File: rtl/clause_mem.sv
// Clause store: one write port, one registered read port, array not reset.
module clause_mem #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking read of the array gives old data on a same-address write.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/formula_loader.sv
// Streams pos/neg literal-mask word pairs into clause storage,
// dropping tautologies and stopping on a terminator or a full store.
module formula_loader
    import common::*;
#(
    parameter  int NUM_LIT     = number_literal,
    parameter  int MAX_CLAUSES = number_clause,
    localparam int AW          = $clog2(MAX_CLAUSES),
    localparam int CW          = $clog2(MAX_CLAUSES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               in_valid,
    input  logic [NUM_LIT-1:0] in_word,
    output logic               in_ready,
    input  logic [AW-1:0]      rd_addr,
    output logic [NUM_LIT-1:0] rd_pos,
    output logic [NUM_LIT-1:0] rd_neg,
    output logic [CW-1:0]      clause_count,
    output logic [CW-1:0]      taut_count,
    output logic               ended,
    output logic               full,
    output logic               aborted
);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [NUM_LIT-1:0]   r_pos;
    logic [CW-1:0]        r_clause_count;
    logic [CW-1:0]        r_taut_count;
    logic                 r_ended;
    logic                 r_full;
    logic                 r_aborted;

    logic                 w_ready;
    logic                 w_store;
    logic                 w_accept;
    logic                 w_term;
    logic                 w_taut;
    logic                 w_hit_max;
    logic                 w_in_session;
    logic [CW-1:0]        w_count_inc;
    logic [2*NUM_LIT-1:0] w_rd_data;

    assign w_accept     = in_valid && w_ready;
    assign w_term       = (r_pos == '0) && (in_word == '0);
    assign w_taut       = |(r_pos & in_word);
    assign w_count_inc  = r_clause_count + CW'(1);
    assign w_hit_max    = (w_count_inc == CW'(MAX_CLAUSES));
    assign w_in_session = (r_state == POS) || (r_state == NEG);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (load) w_next = POS;
            end
            POS: begin
                if (!load)         w_next = IDLE;
                else if (w_accept) w_next = NEG;
            end
            NEG: begin
                if (!load) begin
                    w_next = IDLE;
                end else if (w_accept) begin
                    if (w_term)         w_next = DONE;
                    else if (w_taut)    w_next = POS;
                    else if (w_hit_max) w_next = DONE;
                    else                w_next = POS;
                end
            end
            DONE: begin
                if (!load) w_next = IDLE;
            end
        endcase
    end

    // Dropping load masks in_ready so no word slips in on an abort edge.
    always_comb begin
        w_ready = 1'b0;
        w_store = 1'b0;
        unique case (r_state)
            POS:     w_ready = load;
            NEG: begin
                w_ready = load;
                w_store = w_accept && !w_term && !w_taut;
            end
            default: w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pos          <= '0;
            r_clause_count <= '0;
            r_taut_count   <= '0;
            r_ended        <= 1'b0;
            r_full         <= 1'b0;
            r_aborted      <= 1'b0;
        end else begin
            if (r_state == IDLE && load) begin
                r_clause_count <= '0;
                r_taut_count   <= '0;
                r_ended        <= 1'b0;
                r_full         <= 1'b0;
                r_aborted      <= 1'b0;
            end
            if (w_in_session && !load) begin
                r_aborted <= 1'b1;
            end
            if (r_state == POS && w_accept) begin
                r_pos <= in_word;
            end
            if (r_state == NEG && w_accept) begin
                if (w_term) begin
                    r_ended <= 1'b1;
                end else if (w_taut) begin
                    if (r_taut_count != '1) begin
                        r_taut_count <= r_taut_count + CW'(1);
                    end
                end else begin
                    r_clause_count <= w_count_inc;
                    if (w_hit_max) begin
                        r_full  <= 1'b1;
                        r_ended <= 1'b1;
                    end
                end
            end
        end
    end

    clause_mem #(
        .WIDTH (2 * NUM_LIT),
        .DEPTH (MAX_CLAUSES)
    ) u_mem (
        .i_clock   (clock),
        .i_rst_n   (reset),
        .i_wr_en   (w_store),
        .i_wr_addr (r_clause_count[AW-1:0]),
        .i_wr_data ({r_pos, in_word}),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign in_ready     = w_ready;
    assign rd_pos       = w_rd_data[2*NUM_LIT-1:NUM_LIT];
    assign rd_neg       = w_rd_data[NUM_LIT-1:0];
    assign clause_count = r_clause_count;
    assign taut_count   = r_taut_count;
    assign ended        = r_ended;
    assign full         = r_full;
    assign aborted      = r_aborted;

endmodule
